// File: rtl/mdu_seq_pkg.sv
// Shared decode constants: ALU opcodes, MDU operation codes, MDU FSM states
// and the step-core mode select.
package mdu_seq_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_t;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_t;

    // True for the four opcodes that start a 32-step iterative operation.
    function automatic logic is_muldiv(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Control-unit <-> MDU bus: opcode and operands in, HI/LO and stall/busy out.
interface mdu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic [2:0]       mdu;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             stall;
    logic             busy;

    modport master (
        output mdu, rdata1, rdata2,
        input  hi, lo, stall, busy
    );

    modport slave (
        input  mdu, rdata1, rdata2,
        output hi, lo, stall, busy
    );
endinterface

// File: rtl/mdu_step_core.sv
// One radix-2 iteration of the multiplier/divider datapath.
// Multiply: {acc,rem} is the partial product, rem[0] is the next multiplier bit.
// Divide:   acc is the partial remainder, rem shifts dividend bits out at the
//           top and quotient bits in at the bottom.
module mdu_step_core
    import mdu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  step_mode_t       mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] rem,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] rem_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Shift-add for multiply, restoring shift-subtract for divide.
    // An explicit compare decides the subtract so a zero divisor still shifts
    // the dividend into acc and sets every quotient bit.
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, (rem[0] ? operand : '0)};
        shifted  = {acc, rem[WIDTH-1]};
        ge       = (shifted >= {1'b0, operand});
        diff     = shifted[WIDTH-1:0] - operand;
        acc_next = acc;
        rem_next = rem;
        if (mode == STEP_MUL) begin
            acc_next = sum[WIDTH:1];
            rem_next = {sum[0], rem[WIDTH-1:1]};
        end else begin
            acc_next = ge ? diff : shifted[WIDTH-1:0];
            rem_next = {rem[WIDTH-2:0], ge};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with HI/LO registers. A mul/div occupies
// the pipeline for 34 cycles: one issue cycle, 32 RUN steps, one DONE cycle.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    mdu_seq_if.slave bus
);

    mdu_op_t          op;
    mdu_state_t       state;
    step_mode_t       mode;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             neg_q;
    logic             neg_r;
    logic             div0;

    logic             issue;
    logic             op_signed;
    logic             op_div;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;

    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   remd;

    assign op        = mdu_op_t'(bus.mdu);
    assign issue     = (state == ST_IDLE) && is_muldiv(op);
    assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign op_div    = (op == MDU_DIV) || (op == MDU_DIVU);

    // Magnitudes: 0x80000000 negates to itself and is then treated as unsigned.
    assign mag1 = (op_signed && bus.rdata1[WIDTH-1]) ? (~bus.rdata1 + 1'b1) : bus.rdata1;
    assign mag2 = (op_signed && bus.rdata2[WIDTH-1]) ? (~bus.rdata2 + 1'b1) : bus.rdata2;

    // Final results are taken from the step core output of the last RUN cycle.
    // A zero divisor skips quotient negation; the remainder path restores the
    // original dividend because it takes the dividend's sign.
    assign prod_mag = {acc_nx, rem_nx};
    assign prod     = neg_q ? (~prod_mag + 1'b1) : prod_mag;
    assign quot     = (neg_q && !div0) ? (~rem_nx + 1'b1) : rem_nx;
    assign remd     = neg_r ? (~acc_nx + 1'b1) : acc_nx;

    assign bus.stall = !rst && ((state == ST_RUN) || issue);
    assign bus.busy  = busy_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    mdu_step_core #(.WIDTH(WIDTH)) u_step (
        .mode     (mode),
        .acc      (acc),
        .operand  (opnd),
        .rem      (rem),
        .acc_next (acc_nx),
        .rem_next (rem_nx)
    );

    // Control FSM, operand capture, iteration counter and HI/LO writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            mode   <= STEP_MUL;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            rem    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        mode   <= op_div ? STEP_DIV : STEP_MUL;
                        cnt    <= '0;
                        acc    <= '0;
                        opnd   <= op_div ? mag2 : mag1;
                        rem    <= op_div ? mag1 : mag2;
                        neg_q  <= op_signed && (bus.rdata1[WIDTH-1] ^ bus.rdata2[WIDTH-1]);
                        neg_r  <= op_signed && bus.rdata1[WIDTH-1];
                        div0   <= op_div && (bus.rdata2 == '0);
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end else if (op == MDU_MTHI) begin
                        hi_q <= bus.rdata1;
                    end else if (op == MDU_MTLO) begin
                        lo_q <= bus.rdata1;
                    end
                end
                ST_RUN: begin
                    acc <= acc_nx;
                    rem <= rem_nx;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        busy_q <= 1'b0;
                        state  <= ST_DONE;
                        if (mode == STEP_DIV) begin
                            hi_q <= remd;
                            lo_q <= quot;
                        end else begin
                            hi_q <= prod[2*WIDTH-1:WIDTH];
                            lo_q <= prod[WIDTH-1:0];
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: stimulus pushes reference results, a monitor
// pops and compares them in the DONE cycle and checks the stall length.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    mdu_seq_if #(.WIDTH(32)) bus ();

    mdu_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    logic [31:0] exp_hi  = '0;
    logic [31:0] exp_lo  = '0;
    bit          mon_prev_busy = 1'b0;
    int unsigned mon_stall_cnt = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endfunction

    // Reference: plain 64-bit arithmetic with C-style truncating division.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa;
        longint      sbv;
        longint      q;
        longint      r;
        e.op = op;
        e.hi = exp_hi;
        e.lo = exp_lo;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            3'd1: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd3: begin
                if (b == 32'd0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; end
                else begin q = sa / sbv; r = sa % sbv; e.lo = q[31:0]; e.hi = r[31:0]; end
            end
            3'd4: begin
                if (b == 32'd0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; end
                else begin e.lo = a / b; e.hi = a % b; end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Drive an issue in the current (IDLE) cycle and record its expected result.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bus.mdu    = op;
        bus.rdata1 = a;
        bus.rdata2 = b;
        e = model(op, a, b);
        sb.push_back(e);
        exp_hi = e.hi;
        exp_lo = e.lo;
    endtask

    // Scramble inputs during RUN (optionally with MTHI) and wait for DONE.
    task automatic finish_op(input bit hostile);
        int unsigned k = 0;
        @(negedge clk);
        bus.mdu    = hostile ? 3'd5 : 3'd0;
        bus.rdata1 = $urandom;
        bus.rdata2 = $urandom;
        #1 check("busy_run", {63'd0, bus.busy}, 64'd1);
        while (bus.busy === 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
            bus.mdu    = (hostile && k < 20) ? 3'd5 : 3'd0;
            bus.rdata1 = $urandom;
            bus.rdata2 = $urandom;
            #1;
        end
        if (bus.busy !== 1'b0) begin
            n_total++;
            $display("FAIL done_timeout: busy=%b after %0d cycles, required 0", bus.busy, k);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit hostile);
        @(negedge clk);
        start_op(op, a, b);
        finish_op(hostile);
    endtask

    // Monitor: count stall cycles and compare HI/LO when busy falls (DONE).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst !== 1'b0) begin
                mon_prev_busy = 1'b0;
                mon_stall_cnt = 0;
            end else begin
                if (bus.stall === 1'b1) mon_stall_cnt++;
                if (mon_prev_busy && bus.busy === 1'b0) begin
                    check("done_stall", {63'd0, bus.stall}, 64'd0);
                    check("stall_cycles", 64'(mon_stall_cnt), 64'd33);
                    if (sb.size() == 0) begin
                        n_total++;
                        $display("FAIL sb_underflow: result with hi=%h lo=%h, required none", bus.hi, bus.lo);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("op%0d_hi", e.op), {32'd0, bus.hi}, {32'd0, e.hi});
                        check($sformatf("op%0d_lo", e.op), {32'd0, bus.lo}, {32'd0, e.lo});
                    end
                    mon_stall_cnt = 0;
                end
                mon_prev_busy = (bus.busy === 1'b1);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] specials [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;

        rst        = 1'b1;
        bus.mdu    = 3'd0;
        bus.rdata1 = '0;
        bus.rdata2 = '0;
        @(negedge clk);
        #1;
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        check("rst_stall", {63'd0, bus.stall}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic cases.
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd4, 32'd7, 32'd0, 1'b0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd0, 1'b0);

        // MTHI then MTLO on consecutive cycles, then mdu 0/7 must hold HI/LO.
        @(negedge clk);
        bus.mdu = 3'd5; bus.rdata1 = 32'h1234_5678;
        #1 check("mthi_stall", {63'd0, bus.stall}, 64'd0);
        @(negedge clk);
        check("mthi_hi", {32'd0, bus.hi}, 64'h1234_5678);
        check("mthi_lo_hold", {32'd0, bus.lo}, {32'd0, exp_lo});
        bus.mdu = 3'd6; bus.rdata1 = 32'h9ABC_DEF0;
        #1 check("mtlo_stall", {63'd0, bus.stall}, 64'd0);
        @(negedge clk);
        check("mtlo_lo", {32'd0, bus.lo}, 64'h9ABC_DEF0);
        check("mtlo_hi_hold", {32'd0, bus.hi}, 64'h1234_5678);
        exp_hi = 32'h1234_5678;
        exp_lo = 32'h9ABC_DEF0;
        bus.mdu = 3'd7; bus.rdata1 = $urandom;
        #1 check("rsvd_stall", {63'd0, bus.stall}, 64'd0);
        @(negedge clk);
        bus.mdu = 3'd0; bus.rdata1 = $urandom;
        @(negedge clk);
        check("idle_hi_hold", {32'd0, bus.hi}, {32'd0, exp_hi});
        check("idle_lo_hold", {32'd0, bus.lo}, {32'd0, exp_lo});
        check("idle_busy", {63'd0, bus.busy}, 64'd0);

        // Reset in the middle of RUN, then reissue on the first edge after release.
        start_op(3'd4, 32'd100, 32'd3);
        @(negedge clk);
        bus.mdu = 3'd0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        bus.mdu = 3'd1;
        #1;
        check("midrst_hi", {32'd0, bus.hi}, 64'd0);
        check("midrst_lo", {32'd0, bus.lo}, 64'd0);
        check("midrst_stall", {63'd0, bus.stall}, 64'd0);
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        sb.delete();
        exp_hi = '0;
        exp_lo = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_op(3'd4, 32'd100, 32'd3);
        finish_op(1'b0);

        // Inputs toggling and mdu=MTHI during RUN must not disturb the result.
        run_op(3'd2, 32'd5, 32'd6, 1'b1);
        @(negedge clk);
        check("hostile_hi_hold", {32'd0, bus.hi}, 64'd0);
        check("hostile_lo_hold", {32'd0, bus.lo}, 64'd30);

        // Randomised mul/div mix with occasional corner operands.
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            if (op >= 3'd3 && $urandom_range(0, 7) == 0) b = '0;
            run_op(op, a, b, 1'b0);
        end

        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, HI and LO width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port mdu, input, 3: operation code from the control unit; 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
REQ-005 SHALL have port rdata1, input, 32: rs operand (multiplicand, dividend, or MTHI/MTLO source).
REQ-006 SHALL have port rdata2, input, 32: rt operand (multiplier or divisor).
REQ-007 SHALL have port hi, output, 32: HI register.
REQ-008 SHALL have port lo, output, 32: LO register.
REQ-009 SHALL have port stall, output, 1: combinational; freezes PC and instruction while high.
REQ-010 SHALL have port busy, output, 1: registered; high while state is RUN.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE with mdu in 1..4 SHALL, at the edge, latch operand magnitudes and operand signs, clear the 5-bit iteration counter, and enter RUN.
REQ-013 stall SHALL be 1 when (IDLE and mdu in 1..4) or when in RUN; stall SHALL be 0 in DONE and otherwise.
REQ-014 RUN SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide. After the step with counter=31, the FSM SHALL enter DONE.
REQ-015 On the RUN-to-DONE edge, hi/lo SHALL be written with the final results. For multiply: hi = product[63:32], lo = product[31:0]. For divide: lo = quotient, hi = remainder.
REQ-016 Latency SHALL be: stall high for exactly 33 cycles (issue cycle plus 32 RUN cycles), results visible in the DONE cycle, and 34 cycles of instruction occupancy in total.
REQ-017 DONE SHALL ignore mdu and return to IDLE on the next edge.
REQ-018 Signed forms (MULT, DIV) SHALL operate on magnitudes, then correct signs:
- product and quotient are negated if the operand signs differ;
- the remainder takes the sign of the dividend;
- magnitude 0x80000000 SHALL be handled as an unsigned 32-bit value.
REQ-019 Divisor = 0 SHALL yield lo = 0xFFFFFFFF and hi = rdata1 as latched, with no sign correction, for both DIV and DIVU, with normal 34-cycle timing.
REQ-020 IDLE with mdu=5 SHALL write hi=rdata1 at the edge, and with mdu=6 SHALL write lo=rdata1 at the edge. In both cases stall SHALL stay 0 and the state SHALL stay IDLE.
REQ-021 mdu=0 and mdu=7 SHALL cause no state change and no register write.
REQ-022 Changes to mdu, rdata1 or rdata2 during RUN SHALL have no effect; only the operands latched at issue are used.
REQ-023 hi/lo SHALL hold their values in every cycle not named in REQ-015 and REQ-020; intermediate products and remainders SHALL live in internal registers only.

Reset
REQ-024 rst SHALL force, asynchronously and at any time, including mid-RUN: state=IDLE, hi=0, lo=0, counter=0, busy=0, and internal accumulators = 0.
REQ-025 While rst is high, stall SHALL be 0 regardless of mdu.
REQ-026 The first edge after rst deasserts SHALL evaluate mdu as in IDLE.

Structure
REQ-027 The mdu operation codes (0..7) and the FSM state encoding SHALL reside in the shared package alongside the ALU opcode constants.
REQ-028 The per-cycle arithmetic step SHALL be a sub-module, mdu_step_core. It takes mode (mul/div), accumulator, operand and remainder, and returns the next-cycle values. mdu_seq owns the FSM, counter, sign logic and hi/lo.

Verification
REQ-029 MULT rdata1=0xFFFFFFFE, rdata2=3 -> stall high for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA in DONE.
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Also MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
REQ-031 Divide cases:
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF;
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0;
- DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=7.
REQ-032 MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> hi and lo updated one edge each, stall never high.
REQ-033 Issue DIVU 100/3, assert rst in RUN cycle 10 -> state IDLE, hi=lo=0, stall=0 immediately. After release, reissue DIVU 100/3 -> lo=33, hi=1.
REQ-034 Issue MULTU 5x6, then toggle rdata1/rdata2 and drive mdu=5 during RUN -> hi=0, lo=30, and no MTHI effect.
